round_fp_pipe: RTL and testbench

- Parametrised, 2-stage pipelined IEEE-754 rounding/packing unit for the FP add/sub path (and later mul/fma), fed by the normaliser.
- Generalised in EXP_W/MAN_W; adds a valid/ready handshake, correct post-rounding overflow, a directed-rounding overflow result, and RISC-V fflags generation.

---
 rtl/round_fp_pipe.sv | 181 ++++++++++++++++++
 tb/tb_round_fp_pipe.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/round_fp_pipe.sv
// round_fp_pipe: two-stage IEEE-754 round/pack unit with valid/ready flow control.
// S1 captures the operand together with the round-up decision and the
// incremented fraction; S2 resolves specials/overflow and registers the
// packed result and the RISC-V fflags {NV,DZ,OF,UF,NX}.
// Optional build macro: ROUND_FP_PIPE_FLAGS_EN (when undefined out_fflags is
// constant zero and no flag logic is built).
module round_fp_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sign,
  input  logic [EXP_W:0]           in_exp,
  input  logic [MAN_W-1:0]         in_man,
  input  logic [2:0]               in_grs,
  input  logic [2:0]               in_rm,
  input  logic                     in_nan,
  input  logic                     in_inf,
  input  logic                     in_invalid,
  input  logic                     in_uflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_result,
  output logic [4:0]               out_fflags
);

  localparam int STAGES = 2;
  localparam logic [EXP_W-1:0]   EXP_ONES = '1;
  localparam logic [EXP_W-1:0]   EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [MAN_W-1:0]   MAN_ONES = '1;
  localparam logic [MAN_W-1:0]   MAN_QNAN = {1'b1, {(MAN_W-1){1'b0}}};
  // One extra headroom bit so the post-round increment can never wrap.
  localparam logic [EXP_W+1:0]   EXP_OVF  = {2'b00, EXP_ONES};

  logic [STAGES:1] vld_pipe;
  logic            s1_adv, s2_adv;

  // S1 state
  logic             s1_sign, s1_nan, s1_inf, s1_uflow, s1_up, s1_carry;
  logic [EXP_W:0]   s1_exp;
  logic [MAN_W-1:0] s1_man, s1_man_inc;
  logic [2:0]       s1_grs, s1_rm;

  // S1 combinational
  logic             up;
  logic             carry;
  logic [MAN_W-1:0] man_inc;

  // S2 combinational
  logic [EXP_W+1:0]   exp_round;
  logic [MAN_W-1:0]   man_round;
  logic               is_zero, ovf, ovf_inf;
  logic [EXP_W+MAN_W:0] res_next;

  assign s2_adv    = !vld_pipe[2] | out_ready;
  assign s1_adv    = !vld_pipe[1] | s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = vld_pipe[2];

  assign {carry, man_inc} = {1'b0, in_man} + (MAN_W+1)'(1);

  // Round-up decision from G/R/S, sign and rounding mode (reserved modes truncate).
  always_comb begin
    up = 1'b0;
    case (in_rm)
      3'b000:  up = in_grs[2] & (in_grs[1] | in_grs[0] | in_man[0]);
      3'b010:  up = in_sign & (|in_grs);
      3'b011:  up = !in_sign & (|in_grs);
      3'b100:  up = in_grs[2];
      default: up = 1'b0;
    endcase
  end

  // Stage valid bits advance only when the stage ahead has room.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
    end else begin
      if (s1_adv) vld_pipe[1] <= in_valid;
      if (s2_adv) vld_pipe[2] <= vld_pipe[1];
    end
  end

  // S1 operand capture; held while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_sign    <= 1'b0;
      s1_exp     <= '0;
      s1_man     <= '0;
      s1_grs     <= '0;
      s1_rm      <= '0;
      s1_nan     <= 1'b0;
      s1_inf     <= 1'b0;
      s1_uflow   <= 1'b0;
      s1_up      <= 1'b0;
      s1_carry   <= 1'b0;
      s1_man_inc <= '0;
    end else if (s1_adv && in_valid) begin
      s1_sign    <= in_sign;
      s1_exp     <= in_exp;
      s1_man     <= in_man;
      s1_grs     <= in_grs;
      s1_rm      <= in_rm;
      s1_nan     <= in_nan;
      s1_inf     <= in_inf;
      s1_uflow   <= in_uflow;
      s1_up      <= up;
      s1_carry   <= carry;
      s1_man_inc <= man_inc;
    end
  end

  assign exp_round = {1'b0, s1_exp} + (EXP_W+2)'(s1_up & s1_carry);
  assign man_round = s1_up ? s1_man_inc : s1_man;
  assign is_zero   = (s1_exp == '0) && (s1_man == '0) && (s1_grs == 3'b000);
  assign ovf       = exp_round >= EXP_OVF;

  // Directed modes that round away from the overflowed value saturate to max finite.
  always_comb begin
    ovf_inf = 1'b0;
    case (s1_rm)
      3'b000, 3'b100: ovf_inf = 1'b1;
      3'b011:         ovf_inf = !s1_sign;
      3'b010:         ovf_inf = s1_sign;
      default:        ovf_inf = 1'b0;
    endcase
  end

  // Result selection in priority order: NaN, inf, underflow, zero, overflow, finite.
  always_comb begin
    res_next = {s1_sign, exp_round[EXP_W-1:0], man_round};
    if (s1_nan)        res_next = {1'b0, EXP_ONES, MAN_QNAN};
    else if (s1_inf)   res_next = {s1_sign, EXP_ONES, {MAN_W{1'b0}}};
    else if (s1_uflow) res_next = {s1_sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
    else if (is_zero)  res_next = {s1_sign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
    else if (ovf)      res_next = ovf_inf ? {s1_sign, EXP_ONES, {MAN_W{1'b0}}}
                                          : {s1_sign, EXP_MAXF, MAN_ONES};
  end

  // S2 result register; held while downstream stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   out_result <= '0;
    else if (s2_adv && vld_pipe[1]) out_result <= res_next;
  end

`ifdef ROUND_FP_PIPE_FLAGS_EN
  logic       s1_invalid;
  logic [4:0] flg_next;

  // Invalid only matters for the flag path, so it is captured here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 s1_invalid <= 1'b0;
    else if (s1_adv && in_valid)  s1_invalid <= in_invalid;
  end

  // Flags follow the same priority as the result; DZ never set here.
  always_comb begin
    flg_next = 5'b00000;
    if (s1_nan)        flg_next = {s1_invalid, 4'b0000};
    else if (s1_inf)   flg_next = 5'b00000;
    else if (s1_uflow) flg_next = 5'b00011;
    else if (is_zero)  flg_next = 5'b00000;
    else if (ovf)      flg_next = 5'b00101;
    else               flg_next = {4'b0000, |s1_grs};
  end

  // Flag register tracks the result register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   out_fflags <= '0;
    else if (s2_adv && vld_pipe[1]) out_fflags <= flg_next;
  end
`else
  logic unused_invalid;
  assign unused_invalid = in_invalid;
  assign out_fflags     = 5'b00000;
`endif

endmodule

// File: tb/tb_round_fp_pipe.sv
// Directed bench for round_fp_pipe (EXP_W=8, MAN_W=23): vector table plus
// backpressure and mid-stream reset sequences.
module tb_round_fp_pipe;

`ifdef ROUND_FP_PIPE_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, in_sign, in_nan, in_inf, in_invalid, in_uflow;
  logic [8:0]  in_exp;
  logic [22:0] in_man;
  logic [2:0]  in_grs, in_rm;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_fflags;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        sign;
    logic [8:0]  exp;
    logic [22:0] man;
    logic [2:0]  grs;
    logic [2:0]  rm;
    logic        nan, inf, inv, uf;
    logic [31:0] res;
    logic [4:0]  flg;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  round_fp_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_man(in_man), .in_grs(in_grs), .in_rm(in_rm),
    .in_nan(in_nan), .in_inf(in_inf), .in_invalid(in_invalid), .in_uflow(in_uflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_fflags(out_fflags)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic s, logic [8:0] e, logic [22:0] m, logic [2:0] g,
                              logic [2:0] rm, logic nan, logic inf, logic inv, logic uf,
                              logic [31:0] res, logic [4:0] flg);
    vec_t v;
    v.sign = s; v.exp = e; v.man = m; v.grs = g; v.rm = rm;
    v.nan = nan; v.inf = inf; v.inv = inv; v.uf = uf; v.res = res; v.flg = flg;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_sign = v.sign; in_exp = v.exp; in_man = v.man; in_grs = v.grs; in_rm = v.rm;
    in_nan = v.nan; in_inf = v.inf; in_invalid = v.inv; in_uflow = v.uf;
  endtask

  function automatic logic [4:0] eflg(input vec_t v);
    return FLAGS_EN ? v.flg : 5'b00000;
  endfunction

  // One isolated transaction with out_ready high; checks exact 2-cycle latency.
  task automatic run_vec(input vec_t v, input string name);
    @(posedge clk); #1;
    drive(v); in_valid = 1'b1;
    @(negedge clk);
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_lat1_valid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_result"}, out_result, v.res);
    chk({name, "_fflags"}, 32'(out_fflags), 32'(eflg(v)));
  endtask

  initial begin
    vec_t bp[4];
    int acc, got, cyc, last;

    vecs[0]  = mk(0, 9'h07F, 23'h000001, 3'b100, 3'b000, 0,0,0,0, 32'h3F800002, 5'b00001);
    vecs[1]  = mk(0, 9'h07F, 23'h000002, 3'b100, 3'b000, 0,0,0,0, 32'h3F800002, 5'b00001);
    vecs[2]  = mk(0, 9'h07F, 23'h7FFFFF, 3'b110, 3'b000, 0,0,0,0, 32'h40000000, 5'b00001);
    vecs[3]  = mk(0, 9'h0FE, 23'h7FFFFF, 3'b100, 3'b000, 0,0,0,0, 32'h7F800000, 5'b00101);
    // Truncating modes leave exponent 0xFE: largest finite, inexact but not overflowed.
    vecs[4]  = mk(0, 9'h0FE, 23'h7FFFFF, 3'b100, 3'b001, 0,0,0,0, 32'h7F7FFFFF, 5'b00001);
    vecs[5]  = mk(1, 9'h0FE, 23'h7FFFFF, 3'b100, 3'b011, 0,0,0,0, 32'hFF7FFFFF, 5'b00001);
    // Pre-round exponent already at all-ones: directed overflow results.
    vecs[6]  = mk(0, 9'h0FF, 23'h000000, 3'b000, 3'b001, 0,0,0,0, 32'h7F7FFFFF, 5'b00101);
    vecs[7]  = mk(1, 9'h0FF, 23'h000000, 3'b000, 3'b011, 0,0,0,0, 32'hFF7FFFFF, 5'b00101);
    vecs[8]  = mk(1, 9'h0FF, 23'h000000, 3'b000, 3'b010, 0,0,0,0, 32'hFF800000, 5'b00101);
    vecs[9]  = mk(1, 9'h000, 23'h000000, 3'b111, 3'b000, 1,0,1,0, 32'h7FC00000, 5'b10000);
    vecs[10] = mk(1, 9'h000, 23'h000000, 3'b111, 3'b000, 0,1,0,0, 32'hFF800000, 5'b00000);
    vecs[11] = mk(1, 9'h000, 23'h000000, 3'b000, 3'b000, 0,0,0,1, 32'h80000000, 5'b00011);
    vecs[12] = mk(1, 9'h000, 23'h000000, 3'b000, 3'b000, 0,0,0,0, 32'h80000000, 5'b00000);
    vecs[13] = mk(0, 9'h07F, 23'h000000, 3'b100, 3'b100, 0,0,0,0, 32'h3F800001, 5'b00001);
    vecs[14] = mk(0, 9'h07F, 23'h000000, 3'b001, 3'b011, 0,0,0,0, 32'h3F800001, 5'b00001);
    vecs[15] = mk(0, 9'h07F, 23'h000000, 3'b111, 3'b010, 0,0,0,0, 32'h3F800000, 5'b00001);
    vecs[16] = mk(0, 9'h07F, 23'h000005, 3'b111, 3'b101, 0,0,0,0, 32'h3F800005, 5'b00001);
    vecs[17] = mk(0, 9'h080, 23'h123456, 3'b000, 3'b000, 0,0,0,0, 32'h40123456, 5'b00000);
    vecs[18] = mk(0, 9'h07F, 23'h000001, 3'b011, 3'b000, 0,0,0,0, 32'h3F800001, 5'b00001);

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(vecs[12]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_fflags", 32'(out_fflags), 32'd0);
    reset_n = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: four back-to-back operands, output stalled for six cycles.
    bp[0] = vecs[2]; bp[1] = vecs[3]; bp[2] = vecs[9]; bp[3] = vecs[11];
    acc = 0; got = 0; cyc = 0; last = 0;
    while (got < 4 && cyc < 40) begin
      @(posedge clk); #1;
      out_ready = (cyc >= 6);
      if (acc < 4) begin drive(bp[acc]); in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(negedge clk);
      if (!out_ready && acc == 2) chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      if (out_valid && !out_ready) chk("bp_hold_result", out_result, bp[got].res);
      if (out_valid && out_ready) begin
        chk($sformatf("bp_result%0d", got), out_result, bp[got].res);
        chk($sformatf("bp_fflags%0d", got), 32'(out_fflags), 32'(eflg(bp[got])));
        if (got > 0) chk("bp_rate", 32'(cyc - last), 32'd1);
        last = cyc;
        got++;
      end
      if (in_valid && in_ready) acc++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_accepted", 32'(acc), 32'd4);
    chk("bp_delivered", 32'(got), 32'd4);

    // Mid-stream reset with two operands in flight.
    out_ready = 1'b0;
    @(posedge clk); #1; drive(vecs[13]); in_valid = 1'b1;
    @(posedge clk); #1; drive(vecs[14]);
    @(posedge clk); #1; in_valid = 1'b0;
    chk("rst_inflight_valid", 32'(out_valid), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_result", out_result, 32'd0);
    chk("rst_mid_fflags", 32'(out_fflags), 32'd0);
    @(negedge clk); reset_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_stale", 32'(out_valid), 32'd0);
    end
    run_vec(vecs[17], "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
